// File: rtl/seq_fsm_pkg.sv
// seq_fsm shared definitions.
// Stepping-mode encodings for the cyclic sequencer.
package seq_fsm_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_UP       = 2'b00;
  localparam mode_t MODE_DOWN     = 2'b01;
  localparam mode_t MODE_PINGPONG = 2'b10;

endpackage

// File: rtl/seq_dwell_timer.sv
// seq_dwell_timer: per-state dwell counter.
// Raises step on the enabled cycle that ends the dwell.
module seq_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // >= so a dwell lowered below the count ends it at once
  assign step = en && !clear && (cnt_q >= dwell);

  // Count enabled cycles; restart on clear or step
  always_comb begin
    cnt_d = cnt_q;
    if (clear || step) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  // Dwell count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_fsm.sv
// seq_fsm: N-state cyclic sequencer with dwell,
// up/down/ping-pong stepping, load and wrap pulse.
module seq_fsm
  import seq_fsm_pkg::*;
#(
  parameter int N_STATES    = 3,
  parameter int DWELL_W     = 8,
  parameter int RESET_STATE = 0,
  localparam int SW =
    ($clog2(N_STATES) > 1) ? $clog2(N_STATES) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic                load,
  input  logic [SW-1:0]       load_state,
  output logic [SW-1:0]       state_out,
  output logic [N_STATES-1:0] state_onehot,
  output logic                wrap
);

  localparam logic [SW-1:0] LAST = SW'(N_STATES - 1);
  localparam logic [SW-1:0] RST  = SW'(RESET_STATE);
  localparam logic [SW-1:0] ONE  = SW'(1);

  logic [SW-1:0] state_q, state_d;
  logic          dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic          step;
  mode_t         mode_m;

  assign mode_m = mode_t'(mode);

  seq_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (load),
    .en     (en),
    .dwell  (dwell),
    .step   (step)
  );

  // Next state, direction and wrap: load > advance > hold
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (load) begin
      state_d = (load_state > LAST) ? '0 : load_state;
      dir_d   = 1'b0;
    end else if (step) begin
      if (state_q > LAST) begin
        state_d = '0;
      end else begin
        unique case (1'b1)
          (mode_m == MODE_DOWN): begin
            if (state_q == '0) begin
              state_d = LAST;
              wrap_d  = 1'b1;
            end else begin
              state_d = state_q - ONE;
            end
          end
          (mode_m == MODE_PINGPONG): begin
            if (!dir_q) begin
              if (state_q == LAST) begin
                state_d = LAST - ONE;
                dir_d   = 1'b1;
                wrap_d  = 1'b1;
              end else begin
                state_d = state_q + ONE;
              end
            end else begin
              if (state_q == '0) begin
                state_d = ONE;
                dir_d   = 1'b0;
                wrap_d  = 1'b1;
              end else begin
                state_d = state_q - ONE;
              end
            end
          end
          default: begin
            if (state_q == LAST) begin
              state_d = '0;
              wrap_d  = 1'b1;
            end else begin
              state_d = state_q + ONE;
            end
          end
        endcase
      end
    end
  end

  // State, direction and wrap registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign state_out    = state_q;
  assign state_onehot = N_STATES'(1) << state_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_seq_fsm.sv
// tb_seq_fsm: directed vectors, scoreboard checked.
// DUT built with five states to exercise odd N.
module tb_seq_fsm;

  localparam logic [1:0] UP = 2'b00;
  localparam logic [1:0] DN = 2'b01;
  localparam logic [1:0] PP = 2'b10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic       load;
  logic [2:0] load_state;
  logic [2:0] state_out;
  logic [4:0] state_onehot;
  logic       wrap;

  int passed = 0;
  int total  = 0;
  int idx    = 0;

  logic [3:0] sb[$];

  seq_fsm #(
    .N_STATES   (5),
    .DWELL_W    (8),
    .RESET_STATE(0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .mode        (mode),
    .dwell       (dwell),
    .load        (load),
    .load_state  (load_state),
    .state_out   (state_out),
    .state_onehot(state_onehot),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d want %0d",
                  nm, act, exp);
  endtask

  // Drive one cycle; expect state es / wrap ew after the edge
  task automatic cyc(input logic e, input logic [1:0] m,
                     input logic [7:0] d, input logic l,
                     input logic [2:0] ls,
                     input logic [2:0] es, input logic ew);
    en = e;
    mode = m;
    dwell = d;
    load = l;
    load_state = ls;
    sb.push_back({es, ew});
    @(negedge clk);
  endtask

  // Monitor: every cycle with a pending expectation
  always @(posedge clk) begin
    logic [3:0] x;
    logic [4:0] oh;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      oh = 5'b00001 << x[3:1];
      idx++;
      chk($sformatf("state#%0d", idx),
          32'(state_out), 32'(x[3:1]));
      chk($sformatf("wrap#%0d", idx),
          32'(wrap), 32'(x[0]));
      chk($sformatf("onehot#%0d", idx),
          32'(state_onehot), 32'(oh));
    end
  end

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    mode = UP;
    dwell = 8'd0;
    load = 1'b0;
    load_state = 3'd0;
    #1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_onehot", 32'(state_onehot), 32'd1);
    chk("rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // UP, dwell 0
    cyc(1, UP, 0, 0, 0, 1, 0);
    cyc(1, UP, 0, 0, 0, 2, 0);
    cyc(1, UP, 0, 0, 0, 3, 0);
    cyc(1, UP, 0, 0, 0, 4, 0);
    cyc(1, UP, 0, 0, 0, 0, 1);
    cyc(1, UP, 0, 0, 0, 1, 0);

    // DOWN, dwell 2, with en freeze mid-dwell
    cyc(1, DN, 2, 0, 0, 1, 0);
    cyc(1, DN, 2, 0, 0, 1, 0);
    cyc(1, DN, 2, 0, 0, 0, 0);
    cyc(1, DN, 2, 0, 0, 0, 0);
    cyc(1, DN, 2, 0, 0, 0, 0);
    cyc(1, DN, 2, 0, 0, 4, 1);
    cyc(1, DN, 2, 0, 0, 4, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, DN, 2, 0, 0, 4, 0);
    cyc(1, DN, 2, 0, 0, 4, 0);
    cyc(1, DN, 2, 0, 0, 3, 0);

    // PINGPONG, dwell 0
    cyc(1, PP, 0, 0, 0, 4, 0);
    cyc(1, PP, 0, 0, 0, 3, 1);
    cyc(1, PP, 0, 0, 0, 2, 0);
    cyc(1, PP, 0, 0, 0, 1, 0);
    cyc(1, PP, 0, 0, 0, 0, 0);
    cyc(1, PP, 0, 0, 0, 1, 1);
    cyc(1, PP, 0, 0, 0, 2, 0);
    cyc(1, PP, 0, 0, 0, 3, 0);
    cyc(1, PP, 0, 0, 0, 4, 0);
    cyc(1, PP, 0, 0, 0, 3, 1);
    cyc(1, PP, 0, 0, 0, 2, 0);
    // switch to UP while descending
    cyc(1, UP, 0, 0, 0, 3, 0);
    cyc(1, UP, 0, 0, 0, 4, 0);
    cyc(1, UP, 0, 0, 0, 0, 1);
    cyc(1, UP, 0, 0, 0, 1, 0);
    // back to PINGPONG: descending dir retained
    cyc(1, PP, 0, 0, 0, 0, 0);
    cyc(1, PP, 0, 0, 0, 1, 1);

    // load mid-dwell, dwell 5
    cyc(1, UP, 5, 0, 0, 1, 0);
    cyc(1, UP, 5, 0, 0, 1, 0);
    cyc(1, UP, 5, 1, 3, 3, 0);
    for (int i = 0; i < 5; i++)
      cyc(1, UP, 5, 0, 0, 3, 0);
    cyc(1, UP, 5, 0, 0, 4, 0);
    cyc(1, UP, 5, 1, 7, 0, 0);
    cyc(0, UP, 5, 1, 2, 2, 0);

    // dwell 7 lowered to 2 at count 5
    for (int i = 0; i < 5; i++)
      cyc(1, UP, 7, 0, 0, 2, 0);
    cyc(1, UP, 2, 0, 0, 3, 0);
    cyc(1, UP, 2, 0, 0, 3, 0);
    cyc(1, UP, 2, 0, 0, 3, 0);
    cyc(1, UP, 2, 0, 0, 4, 0);
    cyc(1, UP, 2, 0, 0, 4, 0);

    // async reset between edges, mid-dwell
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_out), 32'd0);
    chk("arst_onehot", 32'(state_onehot), 32'd1);
    chk("arst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1, UP, 2, 0, 0, 0, 0);
    cyc(1, UP, 2, 0, 0, 0, 0);
    cyc(1, UP, 2, 0, 0, 1, 0);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
